// File: rtl/trigger_capture_if.sv
// trigger_capture_if: ADC sample stream, trigger controls and VGA read port of the capture stage
interface trigger_capture_if #(parameter int ADDR_W = 10);
  logic sample_valid;
  logic [7:0] sample_in;
  logic [7:0] trig_level;
  logic slope;
  logic mode;
  logic frame_start;
  logic [ADDR_W-1:0] x_in;
  logic [7:0] data_out;
  logic [1:0] state_out;
  logic auto_trig;
  logic swapped;
  modport master (
    output sample_valid, sample_in, trig_level, slope, mode, frame_start, x_in,
    input data_out, state_out, auto_trig, swapped
  );
  modport slave (
    input sample_valid, sample_in, trig_level, slope, mode, frame_start, x_in,
    output data_out, state_out, auto_trig, swapped
  );
endinterface

// File: rtl/trigger_capture.sv
// trigger_capture: level/slope trigger with auto timeout, capturing one screen into a ping-pong buffer
module trigger_capture #(
  parameter int DEPTH = 640,
  parameter int ADDR_W = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  trigger_capture_if.slave bus
);
  localparam int CNT_W = $clog2(AUTO_TIMEOUT);
  typedef enum logic [1:0] {WAIT_TRIG = 2'b00, CAPTURE = 2'b01, DONE = 2'b10} state_t;
  state_t state_q, state_d;
  logic disp_bank_q, disp_bank_d, have_frame_q, have_frame_d, prev_valid_q, prev_valid_d;
  logic pend_auto_q, pend_auto_d, auto_trig_q, auto_trig_d, swapped_q, swapped_d;
  logic [7:0] prev_q, prev_d, data_out_q, data_out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr;
  logic we, hit, timeout, in_rng, last;
  logic [7:0] mem [2][DEPTH];
  always_comb begin
    hit = prev_valid_q && (bus.slope ? (prev_q < bus.trig_level && bus.sample_in >= bus.trig_level)
                                     : (prev_q > bus.trig_level && bus.sample_in <= bus.trig_level));
    timeout = bus.mode && count_q == CNT_W'(AUTO_TIMEOUT - 1);
    last = wr_addr_q == ADDR_W'(DEPTH - 1);
    in_rng = int'(bus.x_in) < DEPTH;
    rd_addr = in_rng ? bus.x_in : '0;
    data_out_d = have_frame_q && in_rng ? mem[disp_bank_q][rd_addr] : '0;
    state_d = state_q;
    disp_bank_d = disp_bank_q;
    have_frame_d = have_frame_q;
    prev_valid_d = prev_valid_q;
    pend_auto_d = pend_auto_q;
    auto_trig_d = auto_trig_q;
    swapped_d = 1'b0;
    prev_d = prev_q;
    count_d = count_q;
    wr_addr_d = wr_addr_q;
    we = 1'b0;
    case (state_q)
      WAIT_TRIG: begin
        count_d = bus.mode ? count_q : '0;
        if (bus.sample_valid) begin
          prev_d = bus.sample_in;
          prev_valid_d = 1'b1;
          if (hit || timeout) begin
            we = 1'b1;
            wr_addr_d = ADDR_W'(1);
            pend_auto_d = !hit;
            count_d = '0;
            state_d = CAPTURE;
          end else if (bus.mode) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (bus.sample_valid) begin
          we = 1'b1;
          wr_addr_d = last ? '0 : wr_addr_q + 1'b1;
          state_d = last ? DONE : CAPTURE;
        end
      end
      DONE: begin
        // the write bank becomes visible only at frame start so the display never tears
        if (bus.frame_start) begin
          disp_bank_d = !disp_bank_q;
          have_frame_d = 1'b1;
          auto_trig_d = pend_auto_q;
          swapped_d = 1'b1;
          prev_valid_d = 1'b0;
          state_d = WAIT_TRIG;
        end
      end
      default: state_d = WAIT_TRIG;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_TRIG;
      disp_bank_q <= 1'b0;
      have_frame_q <= 1'b0;
      prev_valid_q <= 1'b0;
      pend_auto_q <= 1'b0;
      auto_trig_q <= 1'b0;
      swapped_q <= 1'b0;
      prev_q <= '0;
      count_q <= '0;
      wr_addr_q <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      disp_bank_q <= disp_bank_d;
      have_frame_q <= have_frame_d;
      prev_valid_q <= prev_valid_d;
      pend_auto_q <= pend_auto_d;
      auto_trig_q <= auto_trig_d;
      swapped_q <= swapped_d;
      prev_q <= prev_d;
      count_q <= count_d;
      wr_addr_q <= wr_addr_d;
      data_out_q <= data_out_d;
    end
  end
  always_ff @(posedge clk)
    if (we && !rst) mem[!disp_bank_q][wr_addr_q] <= bus.sample_in;
  assign bus.data_out = data_out_q;
  assign bus.state_out = state_q;
  assign bus.auto_trig = auto_trig_q;
  assign bus.swapped = swapped_q;
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: random and directed stimulus against a queue-based model of the capture stage
module tb_trigger_capture;
  localparam int DEPTH = 640;
  localparam int AT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  trigger_capture_if #(.ADDR_W(10)) bus ();
  trigger_capture #(.DEPTH(DEPTH), .ADDR_W(10), .AUTO_TIMEOUT(AT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int m_ph, m_prev, m_pv, m_cnt, m_pend, m_auto, m_have, m_swp, m_dout;
  int cap[$];
  int shown[DEPTH];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // model: a screen is the DEPTH samples starting at the trigger sample, shown from the next frame start
  always @(posedge clk) begin
    int s, lv;
    bit trig, frc;
    if (rst) begin
      m_ph = 0; m_pv = 0; m_cnt = 0; m_pend = 0; m_auto = 0; m_have = 0; m_swp = 0; m_dout = 0;
      cap.delete();
    end else begin
      m_dout = (m_have != 0 && int'(bus.x_in) < DEPTH) ? shown[bus.x_in] : 0;
      m_swp = 0;
      s = int'(bus.sample_in);
      lv = int'(bus.trig_level);
      if (m_ph == 0) begin
        if (bus.sample_valid) begin
          trig = m_pv != 0 && (bus.slope ? (m_prev < lv && s >= lv) : (m_prev > lv && s <= lv));
          frc = bus.mode && m_cnt == AT - 1;
          m_prev = s;
          m_pv = 1;
          if (trig || frc) begin
            cap.delete();
            cap.push_back(s);
            m_pend = trig ? 0 : 1;
            m_cnt = 0;
            m_ph = 1;
          end else m_cnt = bus.mode ? m_cnt + 1 : 0;
        end else if (!bus.mode) m_cnt = 0;
      end else if (m_ph == 1) begin
        if (bus.sample_valid) begin
          cap.push_back(s);
          if (cap.size() == DEPTH) m_ph = 2;
        end
      end else if (bus.frame_start) begin
        foreach (shown[i]) shown[i] = cap[i];
        m_have = 1; m_auto = m_pend; m_swp = 1; m_pv = 0; m_ph = 0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("data_out", int'(bus.data_out), m_dout);
    chk("state_out", int'(bus.state_out), m_ph);
    chk("auto_trig", int'(bus.auto_trig), m_auto);
    chk("swapped", int'(bus.swapped), m_swp);
  end
  task automatic cyc(input bit sv, input int s, input bit fs, input int x);
    @(negedge clk);
    bus.sample_valid = sv;
    bus.sample_in = 8'(s);
    bus.frame_start = fs;
    bus.x_in = 10'(x);
  endtask
  task automatic idle();
    cyc(0, 0, 0, $urandom_range(0, 1023));
  endtask
  task automatic read_chk(input string name, input int x, input int exp);
    cyc(0, 0, 0, x);
    idle();
    chk(name, int'(bus.data_out), exp);
  endtask
  task automatic swap_chk(input string name);
    cyc(0, 0, 1, $urandom_range(0, 1023));
    idle();
    chk(name, int'(bus.swapped), 1);
  endtask
  initial begin
    int v, n;
    bus.sample_valid = 0; bus.sample_in = 0; bus.trig_level = 128; bus.slope = 1;
    bus.mode = 0; bus.frame_start = 0; bus.x_in = 0;
    repeat (3) idle();
    chk_en = 1;
    rst = 0;
    chk("reset state", int'(bus.state_out), 0);
    chk("reset auto_trig", int'(bus.auto_trig), 0);
    for (int x = 0; x < DEPTH; x++) cyc(0, 0, 0, x);
    idle();
    chk("reset data_out", int'(bus.data_out), 0);
    // rising trigger on a ramp
    v = 100;
    n = 0;
    while (m_ph != 2 && n < 3000) begin
      if ($urandom_range(0, 3) != 0) begin
        cyc(1, v, 0, $urandom_range(0, 1023));
        v = (v + 10) % 260;
      end else idle();
      n++;
    end
    idle();
    chk("ramp done", int'(bus.state_out), 2);
    repeat (5) cyc(1, $urandom_range(0, 255), 0, $urandom_range(0, 1023));
    swap_chk("ramp swap");
    read_chk("ramp x0", 0, 130);
    read_chk("ramp x1", 1, 140);
    read_chk("ramp x2", 2, 150);
    // falling trigger exactly at the level
    bus.slope = 0;
    cyc(1, 200, 0, 0);
    cyc(1, 150, 0, 0);
    cyc(1, 128, 0, 0);
    idle();
    chk("fall capture", int'(bus.state_out), 1);
    for (int i = 1; i < DEPTH; i++) cyc(1, $urandom_range(0, 255), 0, $urandom_range(0, 1023));
    idle();
    swap_chk("fall swap");
    read_chk("fall x0", 0, 128);
    // auto timeout forces a trigger on the AT-th sample
    bus.slope = 1;
    bus.mode = 1;
    for (int i = 0; i < AT - 1; i++) cyc(1, 50, 0, 0);
    idle();
    chk("auto before timeout", int'(bus.state_out), 0);
    cyc(1, 50, 0, 0);
    idle();
    chk("auto forced", int'(bus.state_out), 1);
    for (int i = 1; i < DEPTH; i++) cyc(1, 50, 0, $urandom_range(0, 1023));
    swap_chk("auto swap");
    chk("auto flag", int'(bus.auto_trig), 1);
    for (int x = 0; x < DEPTH; x++) cyc(0, 0, 0, x);
    read_chk("auto x639", 639, 50);
    bus.mode = 0;
    for (int i = 0; i < 10000; i++) cyc(1, 50, 0, $urandom_range(0, 1023));
    idle();
    chk("normal no trigger", int'(bus.state_out), 0);
    // frame_start during capture and on the final write is ignored
    cyc(1, 100, 0, 0);
    cyc(1, 200, 0, 0);
    for (int i = 1; i < DEPTH; i++) cyc(1, $urandom_range(0, 255), (i % 97 == 0) || i == DEPTH - 1, $urandom_range(0, 1023));
    idle();
    chk("late fs state", int'(bus.state_out), 2);
    chk("late fs no swap", int'(bus.swapped), 0);
    read_chk("old bank kept", 5, 50);
    swap_chk("late fs swap");
    chk("late fs auto", int'(bus.auto_trig), 0);
    read_chk("new bank x0", 0, 200);
    read_chk("x beyond depth", 700, 0);
    // reset in the middle of a capture
    cyc(1, 100, 0, 5);
    cyc(1, 200, 0, 5);
    for (int i = 1; i < 300; i++) cyc(1, $urandom_range(0, 255), 0, 5);
    @(negedge clk);
    rst = 1;
    bus.sample_valid = 0;
    idle();
    rst = 0;
    chk("rst state", int'(bus.state_out), 0);
    chk("rst data_out", int'(bus.data_out), 0);
    // random soak
    for (int seg = 0; seg < 6; seg++) begin
      bus.mode = $urandom_range(0, 1);
      bus.slope = $urandom_range(0, 1);
      bus.trig_level = 8'($urandom_range(0, 255));
      for (int i = 0; i < 1500; i++)
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 199) == 0, $urandom_range(0, 1023));
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
Oscilloscope acquisition stage directly upstream of the pixel colour generator. Takes the ADC sample stream and detects a level/slope trigger, or forces a trigger after a timeout in auto mode. Records one screen of samples into a ping-pong buffer. Serves the displayed bank to the colour generator as data_out indexed by the VGA x coordinate, swapping banks only at frame start so the display never tears.

Parameters:
DEPTH, 640, samples per captured screen (one per pixel column)
ADDR_W, 10, width of x_in and buffer address; 2^ADDR_W >= DEPTH
AUTO_TIMEOUT, 4096, samples accepted in WAIT_TRIG without a trigger before auto mode forces one

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe; sample_in valid this cycle
sample_in  in  8  unsigned ADC sample
trig_level  in  8  unsigned trigger threshold
slope  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
mode  in  1  1 = auto, 0 = normal
frame_start  in  1  one-cycle pulse from VGA sync at start of vertical blank
x_in  in  10  current VGA pixel column
data_out  out  8  displayed sample for column x_in, to the colour generator
state_out  out  2  00 WAIT_TRIG, 01 CAPTURE, 10 DONE
auto_trig  out  1  1 = displayed frame was started by auto timeout
swapped  out  1  one-cycle pulse when display bank toggles

Behaviour:
- Reset: state WAIT_TRIG, disp_bank 0, have_frame 0, prev_valid 0, timeout count 0, wr_addr 0, data_out 0, auto_trig 0, swapped 0. Buffer RAM is not cleared.
- Storage: two banks of DEPTH x 8. Capture writes bank ~disp_bank; display reads bank disp_bank.
- WAIT_TRIG, on each sample_valid:
  - prev <= sample_in; prev_valid <= 1.
  - Trigger only if prev_valid.
  - Rising (slope=1): prev < trig_level AND sample_in >= trig_level.
  - Falling (slope=0): prev > trig_level AND sample_in <= trig_level.
  - On trigger: write sample_in at addr 0, wr_addr <= 1, go CAPTURE, latch pend_auto <= 0.
  - Otherwise, if mode=1: count++. When count reaches AUTO_TIMEOUT-1 on a sample, force the trigger on that sample (same write as above) with pend_auto <= 1.
  - mode=0 holds count at 0. Leaving WAIT_TRIG clears count.
- CAPTURE: each sample_valid writes sample_in at wr_addr, wr_addr++. The write at DEPTH-1 moves the state to DONE next cycle and resets wr_addr to 0. Trigger inputs, slope and mode are ignored during CAPTURE.
- DONE: wait for frame_start. On frame_start:
  - disp_bank toggles, have_frame <= 1, auto_trig <= pend_auto, swapped pulses for 1 cycle.
  - prev_valid <= 0, go WAIT_TRIG.
  - Samples arriving in DONE are discarded.
- frame_start in WAIT_TRIG or CAPTURE: ignored; the display keeps the old bank.
- frame_start in the same cycle as the final CAPTURE write: ignored; the swap happens at the next frame_start.
- Read path: data_out registered, 1-cycle latency from x_in.
  - data_out <= buffer[disp_bank][x_in] if have_frame and x_in < DEPTH; otherwise 0.
  - Reads and writes hit different banks, so there is never a read/write collision.
- slope, trig_level and mode changes in WAIT_TRIG take effect on the next sample_valid comparison.
- rst mid-capture: abort immediately to reset values. The partially written back bank is discarded (have_frame 0 → data_out 0).
- All counters are unsigned and never wrap: wr_addr is bounded by DEPTH-1, count by AUTO_TIMEOUT-1.

Test Plan:
1. Reset, then x_in sweep 0..639 → data_out = 0 for all, state_out = 00, auto_trig = 0.
2. Normal mode, slope=1, level=128, ramp samples 100,110,...,250,0,10,...:
   - Trigger on the sample 130 (prev 120); 640 samples captured; state_out = 10.
   - On frame_start: swapped pulses. x_in=0 → data_out = 130 one cycle later; x_in=1 → 140.
3. slope=0, level=128, samples 200,150,128,...:
   - Trigger on 128 (prev 150 > 128, 128 <= 128). After swap, data_out at x=0 is 128.
4. mode=1, AUTO_TIMEOUT=16, constant sample 50:
   - Forced trigger on the 16th sample; after capture and frame_start, auto_trig = 1 and all 640 columns read 50.
   - Same stimulus with mode=0: no trigger after 10000 samples, state_out stays 00.
5. frame_start pulses during CAPTURE, and in the same cycle as the final write:
   - No swap, display bank unchanged. Swap occurs on the following frame_start.
6. x_in = 700 with a valid frame → data_out = 0. rst asserted at wr_addr 300 → state_out = 00, data_out = 0 next cycle.
